// File: rtl/shift_rotate_seq_if.sv
// Request/response bundle between the control unit and the shift/rotate sequencer.
// The master modport is the issuing control unit; the slave modport is the sequencer.
interface shift_rotate_seq_if;
   logic        start_in;
   logic [2:0]  op_in;
   logic [31:0] data_in;
   logic [4:0]  amount_in;
   logic        busy_out;
   logic        done_out;
   logic        err_out;
   logic [31:0] result_out;

   modport master (
      output start_in, op_in, data_in, amount_in,
      input  busy_out, done_out, err_out, result_out
   );

   modport slave (
      input  start_in, op_in, data_in, amount_in,
      output busy_out, done_out, err_out, result_out
   );
endinterface

// File: rtl/shift_rotate_seq.sv
// Multi-cycle 32-bit shift/rotate sequencer, at most STEP positions per RUN cycle; done pulses ceil(amount/STEP)+1 cycles after start.
// Optional SHIFT_ROTATE_SEQ_SHORTPATH_EN turns rotates above 16 into the shorter opposite-direction rotate.
module shift_rotate_seq #(
   parameter int STEP = 4
) (
   input  logic              clock,
   input  logic              clear,
   shift_rotate_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [2:0] OP_SHR  = 3'd0;
   localparam logic [2:0] OP_SHRA = 3'd1;
   localparam logic [2:0] OP_SHL  = 3'd2;
   localparam logic [2:0] OP_ROR  = 3'd3;
   localparam logic [2:0] OP_ROL  = 3'd4;
   localparam logic [4:0] STEP_W  = 5'(STEP);

   state_t      state, state_nxt;
   logic [2:0]  op_q, op_ld;
   logic [4:0]  rem_q, rem_ld, step_s;
   logic        err_q, op_bad;
   logic [31:0] acc_q, step_res;

   assign op_bad = (bus.op_in > OP_ROL);
   assign step_s = (rem_q < STEP_W) ? rem_q : STEP_W;

   // Operation and count as they are latched on an accepted start.
   always_comb begin
      op_ld  = bus.op_in;
      rem_ld = bus.amount_in;
      if (op_bad) begin
         rem_ld = 5'd0;
      end
`ifdef SHIFT_ROTATE_SEQ_SHORTPATH_EN
      else if ((bus.op_in == OP_ROR || bus.op_in == OP_ROL) && bus.amount_in > 5'd16) begin
         op_ld  = (bus.op_in == OP_ROR) ? OP_ROL : OP_ROR;
         rem_ld = 5'(6'd32 - {1'b0, bus.amount_in});
      end
`endif
   end

   always_comb begin
      step_res = acc_q;
      case (op_q)
         OP_SHR:  step_res = acc_q >> step_s;
         OP_SHRA: step_res = $unsigned($signed(acc_q) >>> step_s);
         OP_SHL:  step_res = acc_q << step_s;
         OP_ROR:  step_res = (acc_q >> step_s) | (acc_q << (6'd32 - {1'b0, step_s}));
         OP_ROL:  step_res = (acc_q << step_s) | (acc_q >> (6'd32 - {1'b0, step_s}));
         default: step_res = acc_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start_in) begin
               state_nxt = (rem_ld == 5'd0) ? DONE : RUN;
            end
         end
         RUN:     state_nxt = (rem_q <= STEP_W) ? DONE : RUN;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         op_q  <= 3'd0;
         rem_q <= 5'd0;
         err_q <= 1'b0;
         acc_q <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_in) begin
                  op_q  <= op_ld;
                  rem_q <= rem_ld;
                  err_q <= op_bad;
                  acc_q <= bus.data_in;
               end
            end
            RUN: begin
               acc_q <= step_res;
               rem_q <= rem_q - step_s;
            end
            DONE:    err_q <= 1'b0;
            default: err_q <= 1'b0;
         endcase
      end
   end

   always_comb begin
      bus.busy_out   = (state != IDLE);
      bus.done_out   = (state == DONE);
      bus.err_out    = (state == DONE) && err_q;
      bus.result_out = acc_q;
   end
endmodule
